// File: rtl/mul_div_if.sv
// +----------------------------------------------------------------------------+
// | Module      : mul_div_if                                                   |
// | Description : Request/response bundle between the register-file read path |
// |               and the iterative multiply/divide unit.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Signals
//   start          request; honoured only when the unit is idle or done
//   op             00 MULL, 01 MULH, 10 DIV, 11 REM (all unsigned)
//   operand_a      multiplicand / dividend (ReadData1)
//   operand_b      multiplier / divisor (ReadData2)
//   dest_in        destination register rd
//   busy           high while an operation is iterating
//   done           one-cycle pulse, result valid in that cycle
//   result         product / quotient / remainder, held until next accept
//   result_rd      rd captured with the accepted request
//   result_reg_wre done and result_rd is not register 0
//   div_by_zero    high with done for a DIV/REM whose divisor was zero
// Modports
//   master : the requester (CPU side)
//   slave  : the multiply/divide unit
`default_nettype none

interface mul_div_if #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
);
  logic                  start;
  logic [1:0]            op;
  logic [WIDTH-1:0]      operand_a;
  logic [WIDTH-1:0]      operand_b;
  logic [REG_ADDR_W-1:0] dest_in;
  logic                  busy;
  logic                  done;
  logic [WIDTH-1:0]      result;
  logic [REG_ADDR_W-1:0] result_rd;
  logic                  result_reg_wre;
  logic                  div_by_zero;

  modport master (
    output start, op, operand_a, operand_b, dest_in,
    input  busy, done, result, result_rd, result_reg_wre, div_by_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_in,
    output busy, done, result, result_rd, result_reg_wre, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/mul_div_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Iterative unsigned multiply/divide unit. Shift-add multiply  |
// |               and restoring divide, one bit per clock, WIDTH iterations.   |
// |               Optional feature macro: MULDIV_EARLY_ZERO_EN (zero operand   |
// |               short-circuit; results identical, latency data-dependent).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// Ports
//   clk    in   clock, all state changes on the rising edge
//   rst_n  in   synchronous active-low reset
//   bus    slave modport of mul_div_if (request operands, result, status)
`default_nettype none

module mul_div_unit #(
  parameter int WIDTH      = 16,
  parameter int REG_ADDR_W = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  mul_div_if.slave    bus
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]            r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [1:0]            r_op;
  // Operand that stays fixed during iteration: multiplicand for MUL,
  // divisor for DIV/REM.
  logic [WIDTH-1:0]      r_opnd;
  // r_hi/r_lo are shared: product high/low halves for MUL (r_lo starts as
  // the multiplier and is shifted out as product bits shift in), partial
  // remainder / dividend-becoming-quotient for DIV.
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_dbz;
  logic [WIDTH-1:0]      r_result;
  logic [REG_ADDR_W-1:0] r_result_rd;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_skip;
  logic [WIDTH:0]        w_add;
  logic [WIDTH:0]        w_shift;
  logic [WIDTH:0]        w_diff;
  logic                  w_ge;
  logic [WIDTH-1:0]      w_hi_next;
  logic [WIDTH-1:0]      w_lo_next;
  logic [WIDTH-1:0]      w_step_result;
  logic [WIDTH-1:0]      w_early_result;
  logic                  w_done;

  assign w_accept = bus.start && ((r_state == c_idle) || (r_state == c_done));
  assign w_last   = (r_cnt == c_cnt_w'(WIDTH - 1));

`ifdef MULDIV_EARLY_ZERO_EN
  // Set when the accepted operation has a trivially known result; the unit
  // then spends a single cycle in RUN and finishes.
  logic r_early;
  assign w_skip = r_early;
`else
  assign w_skip = 1'b0;
`endif

  // Multiply step: add multiplicand when the current multiplier bit is set,
  // then shift the {carry, hi, lo} accumulator right by one.
  assign w_add = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};

  // Divide step: shift the next dividend bit into the partial remainder and
  // trial-subtract the divisor. The partial remainder is always below twice
  // the divisor, so the top bit of the difference is a clean borrow flag.
  assign w_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_opnd};
  assign w_ge    = ~w_diff[WIDTH];

  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (r_op[1]) begin
      w_hi_next = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_lo_next = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_next = w_add[WIDTH:1];
      w_lo_next = {w_add[0], r_lo[WIDTH-1:1]};
    end
  end

  // MULH and REM live in the high half, MULL and DIV in the low half.
  assign w_step_result = r_op[0] ? w_hi_next : w_lo_next;

  // Zero short-circuit values: any MUL with a zero operand is 0; divide by
  // zero gives all-ones quotient and the dividend (held in r_lo) as remainder.
  assign w_early_result = r_op[1] ? (r_op[0] ? r_lo : {WIDTH{1'b1}})
                                  : {WIDTH{1'b0}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_idle;
      r_cnt       <= '0;
      r_op        <= 2'b00;
      r_opnd      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rd        <= '0;
      r_dbz       <= 1'b0;
      r_result    <= '0;
      r_result_rd <= '0;
`ifdef MULDIV_EARLY_ZERO_EN
      r_early     <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_idle, c_done: begin
          if (w_accept) begin
            r_state <= c_run;
            r_cnt   <= '0;
            r_op    <= bus.op;
            r_rd    <= bus.dest_in;
            r_hi    <= '0;
            r_dbz   <= bus.op[1] && (bus.operand_b == '0);
            if (bus.op[1]) begin
              r_opnd <= bus.operand_b;
              r_lo   <= bus.operand_a;
            end else begin
              r_opnd <= bus.operand_a;
              r_lo   <= bus.operand_b;
            end
`ifdef MULDIV_EARLY_ZERO_EN
            r_early <= (bus.operand_b == '0) ||
                       (!bus.op[1] && (bus.operand_a == '0));
`endif
          end else begin
            r_state <= c_idle;
          end
        end
        c_run: begin
          if (w_skip) begin
            r_state     <= c_done;
            r_result    <= w_early_result;
            r_result_rd <= r_rd;
          end else begin
            r_hi  <= w_hi_next;
            r_lo  <= w_lo_next;
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (w_last) begin
              r_state     <= c_done;
              r_result    <= w_step_result;
              r_result_rd <= r_rd;
            end
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign w_done             = (r_state == c_done);
  assign bus.busy           = (r_state == c_run);
  assign bus.done           = w_done;
  assign bus.result         = r_result;
  assign bus.result_rd      = r_result_rd;
  assign bus.result_reg_wre = w_done && (r_result_rd != '0);
  assign bus.div_by_zero    = w_done && r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_div_unit                                              |
// | Description : Directed self-checking bench for mul_div_unit.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_mul_div_unit;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;

  mul_div_if #(.WIDTH(16), .REG_ADDR_W(4)) bus ();

  mul_div_unit #(.WIDTH(16), .REG_ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MULDIV_EARLY_ZERO_EN
  localparam int c_zero_lat = 2;
`else
  localparam int c_zero_lat = 17;
`endif

  // Issue one request from the current cycle and wait for done (bounded).
  // cyc = cycles from the Start cycle to the done cycle, -1 on timeout.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] rd,
                        output int cyc, output int wre_cnt);
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.dest_in   = rd;
    bus.start     = 1'b1;
    cyc     = -1;
    wre_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (i == 1) bus.start = 1'b0;
      if (bus.result_reg_wre) wre_cnt++;
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0; bus.dest_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_miss++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_vec++; if (bus.result !== 16'h0000) begin n_miss++; $display("FAIL reset_result: got %h want 0000", bus.result); end
    n_vec++; if (bus.result_rd !== 4'h0) begin n_miss++; $display("FAIL reset_rd: got %h want 0", bus.result_rd); end
    n_vec++; if ({bus.result_reg_wre, bus.div_by_zero} !== 2'b00) begin n_miss++; $display("FAIL reset_flags: got %b want 00", {bus.result_reg_wre, bus.div_by_zero}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mull();
    int cyc, wre;
    run_op(2'b00, 16'h1234, 16'h0010, 4'd3, cyc, wre);
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL mull_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'h2340) begin n_miss++; $display("FAIL mull_result: got %h want 2340", bus.result); end
    n_vec++; if (bus.result_rd !== 4'd3) begin n_miss++; $display("FAIL mull_rd: got %h want 3", bus.result_rd); end
    n_vec++; if (wre !== 1) begin n_miss++; $display("FAIL mull_wre_cycles: got %0d want 1", wre); end
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_miss++; $display("FAIL mull_dbz: got %b want 0", bus.div_by_zero); end
    @(posedge clk); #1;
    n_vec++; if ({bus.done, bus.result_reg_wre} !== 2'b00) begin n_miss++; $display("FAIL mull_pulse_end: got %b want 00", {bus.done, bus.result_reg_wre}); end
    n_vec++; if (bus.result !== 16'h2340) begin n_miss++; $display("FAIL mull_result_held: got %h want 2340", bus.result); end
  endtask

  task automatic test_back_to_back();
    int cyc, wre;
    run_op(2'b01, 16'hFFFF, 16'hFFFF, 4'd5, cyc, wre);
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL mulh_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'hFFFE) begin n_miss++; $display("FAIL mulh_result: got %h want fffe", bus.result); end
    // Next Start issued in the DONE cycle.
    run_op(2'b00, 16'hFFFF, 16'hFFFF, 4'd5, cyc, wre);
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL b2b_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'h0001) begin n_miss++; $display("FAIL b2b_mull_result: got %h want 0001", bus.result); end
  endtask

  task automatic test_div_rem();
    int cyc, wre;
    run_op(2'b10, 16'd100, 16'd7, 4'd4, cyc, wre);
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL div_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'd14) begin n_miss++; $display("FAIL div_result: got %h want 000e", bus.result); end
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_miss++; $display("FAIL div_dbz: got %b want 0", bus.div_by_zero); end
    run_op(2'b11, 16'd100, 16'd7, 4'd4, cyc, wre);
    n_vec++; if (bus.result !== 16'd2) begin n_miss++; $display("FAIL rem_result: got %h want 0002", bus.result); end
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_miss++; $display("FAIL rem_dbz: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_div_zero();
    int cyc, wre;
    run_op(2'b10, 16'h1234, 16'h0000, 4'd7, cyc, wre);
    n_vec++; if (cyc !== c_zero_lat) begin n_miss++; $display("FAIL dz_div_latency: got %0d want %0d", cyc, c_zero_lat); end
    n_vec++; if (bus.result !== 16'hFFFF) begin n_miss++; $display("FAIL dz_div_result: got %h want ffff", bus.result); end
    n_vec++; if (bus.div_by_zero !== 1'b1) begin n_miss++; $display("FAIL dz_div_flag: got %b want 1", bus.div_by_zero); end
    run_op(2'b11, 16'h1234, 16'h0000, 4'd7, cyc, wre);
    n_vec++; if (cyc !== c_zero_lat) begin n_miss++; $display("FAIL dz_rem_latency: got %0d want %0d", cyc, c_zero_lat); end
    n_vec++; if (bus.result !== 16'h1234) begin n_miss++; $display("FAIL dz_rem_result: got %h want 1234", bus.result); end
    n_vec++; if (bus.div_by_zero !== 1'b1) begin n_miss++; $display("FAIL dz_rem_flag: got %b want 1", bus.div_by_zero); end
    @(posedge clk); #1;
    n_vec++; if (bus.div_by_zero !== 1'b0) begin n_miss++; $display("FAIL dz_flag_clear: got %b want 0", bus.div_by_zero); end
  endtask

  task automatic test_start_ignored();
    int cyc;
    cyc = -1;
    bus.op = 2'b10; bus.operand_a = 16'd100; bus.operand_b = 16'd7; bus.dest_in = 4'd6;
    bus.start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (i == 5) begin
        bus.op = 2'b00; bus.operand_a = 16'd3; bus.operand_b = 16'd3; bus.dest_in = 4'd9;
        bus.start = 1'b1;
      end
      if (bus.done) begin
        cyc = i;
        break;
      end
    end
    bus.start = 1'b0;
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL ign_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'd14) begin n_miss++; $display("FAIL ign_result: got %h want 000e", bus.result); end
    n_vec++; if (bus.result_rd !== 4'd6) begin n_miss++; $display("FAIL ign_rd: got %h want 6", bus.result_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int dcnt;
    dcnt = 0;
    bus.op = 2'b10; bus.operand_a = 16'd100; bus.operand_b = 16'd7; bus.dest_in = 4'd2;
    bus.start = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    n_vec++; if (bus.busy !== 1'b1) begin n_miss++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_vec++; if (bus.busy !== 1'b0) begin n_miss++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    n_vec++; if (bus.result !== 16'h0000) begin n_miss++; $display("FAIL abort_result: got %h want 0000", bus.result); end
    n_vec++; if (bus.result_rd !== 4'h0) begin n_miss++; $display("FAIL abort_rd: got %h want 0", bus.result_rd); end
    for (int i = 0; i < 25; i++) begin
      if (bus.done || bus.result_reg_wre) dcnt++;
      @(posedge clk); #1;
    end
    n_vec++; if (dcnt !== 0) begin n_miss++; $display("FAIL abort_no_done: got %0d done cycles want 0", dcnt); end
  endtask

  task automatic test_rd_zero();
    int cyc, wre;
    run_op(2'b00, 16'd5, 16'd5, 4'd0, cyc, wre);
    n_vec++; if (cyc !== 17) begin n_miss++; $display("FAIL rd0_latency: got %0d want 17", cyc); end
    n_vec++; if (bus.result !== 16'd25) begin n_miss++; $display("FAIL rd0_result: got %h want 0019", bus.result); end
    n_vec++; if (wre !== 0) begin n_miss++; $display("FAIL rd0_wre: got %0d cycles want 0", wre); end
    n_vec++; if (bus.result_reg_wre !== 1'b0) begin n_miss++; $display("FAIL rd0_wre_done: got %b want 0", bus.result_reg_wre); end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_mull();
    test_back_to_back();
    test_div_rem();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    test_rd_zero();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
